// File: rtl/intersection_light_ctrl.sv
`default_nettype none
`timescale 1ns/1ps

// ============================================================================
// Module      : intersection_light_ctrl
// Description : Two-road intersection sequencer. The main (north-south) road
//               rests on green. The side (east-west) road gets a fixed green
//               after a minimum main-green time, and only when a side vehicle
//               or a pedestrian is waiting. Every change of right-of-way goes
//               through yellow and then an all-red clearance.
// Ports       : clk          - system clock, rising edge
//               reset        - asynchronous active-high reset
//               side_sensor  - level, side-road vehicle waiting
//               ped_req      - pedestrian button, sampled every edge and latched
//               light_ns     - main-road light code (GREEN/YELLOW/RED)
//               light_ew     - side-road light code (GREEN/YELLOW/RED)
//               walk         - walk signal for crossing the main road
//               ped_wait     - pedestrian request latch is set
// Revision    : 1.0 - initial release
// ============================================================================

// Light encoding shared with the car FSMs (light.v). The guards let this file
// stand alone or follow light.v in a compile list.
`ifndef GREEN
`define GREEN  2'b00
`endif
`ifndef YELLOW
`define YELLOW 2'b01
`endif
`ifndef RED
`define RED    2'b10
`endif

module intersection_light_ctrl #(
  parameter int unsigned MIN_GREEN     = 8,
  parameter int unsigned SIDE_GREEN    = 6,
  parameter int unsigned YELLOW_CYCLES = 3,
  parameter int unsigned ALLRED_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       side_sensor,
  input  logic       ped_req,
  output logic [1:0] light_ns,
  output logic [1:0] light_ew,
  output logic       walk,
  output logic       ped_wait
);

  localparam logic [2:0] S_NS_GO   = 3'd0;
  localparam logic [2:0] S_NS_SLOW = 3'd1;
  localparam logic [2:0] S_CLR_A   = 3'd2;
  localparam logic [2:0] S_EW_GO   = 3'd3;
  localparam logic [2:0] S_EW_SLOW = 3'd4;
  localparam logic [2:0] S_CLR_B   = 3'd5;

  // Terminal timer values: each timed state ends on the edge at which the
  // timer shows its duration minus one.
  localparam logic [7:0] c_min_green_m1  = 8'(MIN_GREEN - 1);
  localparam logic [7:0] c_side_green_m1 = 8'(SIDE_GREEN - 1);
  localparam logic [7:0] c_yellow_m1     = 8'(YELLOW_CYCLES - 1);
  localparam logic [7:0] c_allred_m1     = 8'(ALLRED_CYCLES - 1);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [7:0] r_timer;
  logic [7:0] w_timer_nxt;
  logic       r_ped;
  logic       w_ped_nxt;
  logic       w_req;
  logic       w_enter_ew;

  // A fresh button press counts in the same edge it is sampled, so the
  // latch is ORed with the raw input for the leave-green decision.
  assign w_req = side_sensor | r_ped | ped_req;

  // --------------------------------------------------------------------------
  // State register (state, phase timer, pedestrian latch)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_CLR_B;
      r_timer <= 8'd0;
      r_ped   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_ped   <= w_ped_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state, timer and latch logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_NS_GO:   if ((r_timer == c_min_green_m1) && w_req) w_state_nxt = S_NS_SLOW;
      S_NS_SLOW: if (r_timer == c_yellow_m1)               w_state_nxt = S_CLR_A;
      S_CLR_A:   if (r_timer == c_allred_m1)               w_state_nxt = S_EW_GO;
      S_EW_GO:   if (r_timer == c_side_green_m1)           w_state_nxt = S_EW_SLOW;
      S_EW_SLOW: if (r_timer == c_yellow_m1)               w_state_nxt = S_CLR_B;
      S_CLR_B:   if (r_timer == c_allred_m1)               w_state_nxt = S_NS_GO;
      default:                                             w_state_nxt = S_CLR_B;
    endcase

    // Timer restarts on every phase change; in main green it parks at the
    // minimum so a late request is served on the edge that first sees it.
    if (w_state_nxt != r_state) begin
      w_timer_nxt = 8'd0;
    end else if ((r_state == S_NS_GO) && (r_timer == c_min_green_m1)) begin
      w_timer_nxt = r_timer;
    end else begin
      w_timer_nxt = r_timer + 8'd1;
    end

    // Requests made while the walk phase is showing, or on the edge that
    // starts it, are already being served, so they are not remembered.
    w_enter_ew = (r_state == S_CLR_A) && (w_state_nxt == S_EW_GO);
    if (w_enter_ew) begin
      w_ped_nxt = 1'b0;
    end else if (r_state == S_EW_GO) begin
      w_ped_nxt = r_ped;
    end else begin
      w_ped_nxt = r_ped | ped_req;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode (state register only, no input paths)
  // --------------------------------------------------------------------------
  always_comb begin
    light_ns = `RED;
    light_ew = `RED;
    walk     = 1'b0;
    ped_wait = r_ped;
    case (r_state)
      S_NS_GO:   light_ns = `GREEN;
      S_NS_SLOW: light_ns = `YELLOW;
      S_EW_GO: begin
        light_ew = `GREEN;
        walk     = 1'b1;
      end
      S_EW_SLOW: light_ew = `YELLOW;
      default: begin
        light_ns = `RED;
        light_ew = `RED;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Safety properties
  // --------------------------------------------------------------------------
  a_never_both_open: assert property (@(posedge clk) disable iff (reset)
    (light_ns == `RED) || (light_ew == `RED));

  a_ns_no_green_to_red: assert property (@(posedge clk) disable iff (reset)
    ($past(light_ns) == `GREEN) |-> (light_ns != `RED));

  a_ew_no_green_to_red: assert property (@(posedge clk) disable iff (reset)
    ($past(light_ew) == `GREEN) |-> (light_ew != `RED));

endmodule

`default_nettype wire

// File: tb/tb_intersection_light_ctrl.sv
`default_nettype none
`timescale 1ns/1ps

`ifndef GREEN
`define GREEN  2'b00
`endif
`ifndef YELLOW
`define YELLOW 2'b01
`endif
`ifndef RED
`define RED    2'b10
`endif

module tb_intersection_light_ctrl;

  localparam logic [1:0] c_g = `GREEN;
  localparam logic [1:0] c_y = `YELLOW;
  localparam logic [1:0] c_r = `RED;

  typedef struct packed {
    logic [1:0] ns;
    logic [1:0] ew;
    logic       wk;
    logic       pw;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       side_sensor = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] light_ns;
  logic [1:0] light_ew;
  logic       walk;
  logic       ped_wait;

  exp_t q_main[$];
  exp_t q_async[$];
  event ev_async;
  int   checks = 0;
  int   errors = 0;

  intersection_light_ctrl #(
    .MIN_GREEN    (8),
    .SIDE_GREEN   (6),
    .YELLOW_CYCLES(3),
    .ALLRED_CYCLES(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .side_sensor(side_sensor),
    .ped_req    (ped_req),
    .light_ns   (light_ns),
    .light_ew   (light_ew),
    .walk       (walk),
    .ped_wait   (ped_wait)
  );

  always #5 clk = ~clk;

  task automatic compare(input string tag, input exp_t e);
    checks++;
    if (light_ns !== e.ns || light_ew !== e.ew || walk !== e.wk || ped_wait !== e.pw) begin
      errors++;
      $display("FAIL %s #%0d t=%0t: got ns=%b ew=%b walk=%b ped_wait=%b, want ns=%b ew=%b walk=%b ped_wait=%b",
               tag, checks, $time, light_ns, light_ew, walk, ped_wait, e.ns, e.ew, e.wk, e.pw);
    end
  endtask

  // Per-cycle monitor: outputs settle after the rising edge.
  always @(posedge clk) begin
    #2;
    if (q_main.size() > 0) compare("cycle", q_main.pop_front());
  end

  // Immediate (edge-free) monitor, used around reset.
  always @(ev_async) begin
    #1;
    if (q_async.size() > 0) compare("async", q_async.pop_front());
  end

  // Drive inputs at a falling edge and queue what the next rising edge must show.
  task automatic cyc(input logic ss, input logic pr, input logic [1:0] ns,
                     input logic [1:0] ew, input logic wk, input logic pw);
    exp_t e;
    side_sensor = ss;
    ped_req     = pr;
    e.ns = ns; e.ew = ew; e.wk = wk; e.pw = pw;
    q_main.push_back(e);
    @(negedge clk);
  endtask

  task automatic phase(input logic ss, input logic pr, input logic [1:0] ns,
                       input logic [1:0] ew, input logic wk, input logic pw, input int n);
    for (int i = 0; i < n; i++) cyc(ss, pr, ns, ew, wk, pw);
  endtask

  task automatic async_expect(input logic [1:0] ns, input logic [1:0] ew,
                              input logic wk, input logic pw);
    exp_t e;
    e.ns = ns; e.ew = ew; e.wk = wk; e.pw = pw;
    q_async.push_back(e);
    -> ev_async;
  endtask

  // Assert reset (outputs must go all-red at once), hold, release; the
  // interval up to the next edge must still be all-red.
  task automatic do_reset();
    side_sensor = 1'b0;
    ped_req     = 1'b0;
    reset       = 1'b1;
    async_expect(c_r, c_r, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    async_expect(c_r, c_r, 1'b0, 1'b0);
  endtask

  initial begin
    #1;
    // Idle: green rests on the main road indefinitely.
    do_reset();
    phase(0, 0, c_g, c_r, 0, 0, 110);

    // Side sensor held high: full 22-cycle sequence, twice.
    do_reset();
    repeat (2) begin
      phase(1, 0, c_g, c_r, 0, 0, 8);
      phase(1, 0, c_y, c_r, 0, 0, 3);
      phase(1, 0, c_r, c_r, 0, 0, 1);
      phase(1, 0, c_r, c_g, 1, 0, 6);
      phase(1, 0, c_r, c_y, 0, 0, 3);
      phase(1, 0, c_r, c_r, 0, 0, 1);
    end

    // Pedestrian pulse at main-green cycle 2.
    do_reset();
    cyc(0, 0, c_g, c_r, 0, 0);
    cyc(0, 1, c_g, c_r, 0, 1);
    phase(0, 0, c_g, c_r, 0, 1, 6);
    phase(0, 0, c_y, c_r, 0, 1, 3);
    phase(0, 0, c_r, c_r, 0, 1, 1);
    phase(0, 0, c_r, c_g, 1, 0, 6);
    phase(0, 0, c_r, c_y, 0, 0, 3);
    phase(0, 0, c_r, c_r, 0, 0, 1);
    phase(0, 0, c_g, c_r, 0, 0, 30);

    // Side sensor rises at main-green cycle 20; pedestrian presses on the
    // entering edge, mid-walk and on the leaving edge are all ignored.
    do_reset();
    phase(0, 0, c_g, c_r, 0, 0, 19);
    cyc(1, 0, c_y, c_r, 0, 0);
    phase(0, 0, c_y, c_r, 0, 0, 2);
    cyc(0, 0, c_r, c_r, 0, 0);
    cyc(0, 1, c_r, c_g, 1, 0);
    cyc(0, 0, c_r, c_g, 1, 0);
    cyc(0, 1, c_r, c_g, 1, 0);
    phase(0, 0, c_r, c_g, 1, 0, 3);
    cyc(0, 1, c_r, c_y, 0, 0);
    phase(0, 0, c_r, c_y, 0, 0, 2);
    phase(0, 0, c_r, c_r, 0, 0, 1);
    phase(0, 0, c_g, c_r, 0, 0, 30);

    // Late pedestrian press: leaves green on the sampling edge; reset
    // during walk cycle 3.
    cyc(0, 1, c_y, c_r, 0, 1);
    phase(0, 0, c_y, c_r, 0, 1, 2);
    phase(0, 0, c_r, c_r, 0, 1, 1);
    phase(0, 0, c_r, c_g, 1, 0, 3);
    do_reset();
    phase(0, 0, c_g, c_r, 0, 0, 10);

    // Reset while the latch is set: the request is lost.
    cyc(0, 1, c_y, c_r, 0, 1);
    do_reset();
    phase(0, 0, c_g, c_r, 0, 0, 20);

    if (q_main.size() != 0 || q_async.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d cycle and %0d async expectations never compared, want 0",
               q_main.size(), q_async.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 ns");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
